// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: mnemonic codes,
// MIPS opcode/funct constants (matching the P4 decoder) and state encoding.
// Optional feature macro: INSTR_ENC_LI_PSEUDO_EN (adds the LI_HI state).
package instr_enc_pkg;

    // Mnemonic codes carried on in_mnem; 12-15 are illegal.
    typedef enum logic [3:0] {
        MN_ADDU = 4'd0,
        MN_SUBU = 4'd1,
        MN_ORI  = 4'd2,
        MN_LW   = 4'd3,
        MN_SW   = 4'd4,
        MN_BEQ  = 4'd5,
        MN_LUI  = 4'd6,
        MN_JAL  = 4'd7,
        MN_JR   = 4'd8,
        MN_SLTU = 4'd9,
        MN_NOP  = 4'd10,
        MN_LI   = 4'd11
    } mnem_t;

    // Primary opcodes.
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    // SPECIAL funct codes.
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // Output stage state: EMPTY (no word), FULL (one word held),
    // LI_HI (upper half of an LI held, lower half queued internally).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1
`ifdef INSTR_ENC_LI_PSEUDO_EN
        ,
        ST_LI_HI = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder.
// slave: the encoder's view; master: the producer/consumer (bench) view.
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [10:0] word_cnt;
    logic        err;

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, word_cnt, err
    );

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, word_cnt, err
    );

endinterface

// File: rtl/instr_enc_comb.sv
// Pure combinational encoder: mnemonic + fields -> 32-bit MIPS word.
// For LI (only with INSTR_ENC_LI_PSEUDO_EN) word is the LUI half and
// lo_word the ORI half; two_word flags the expansion.
module instr_enc_comb
    import instr_enc_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [31:0] lo_word,
    output logic        legal,
    output logic        two_word
);

    // imm bits that no encoding consumes in some builds.
    logic unused_imm;
    assign unused_imm = ^{imm[31:28], imm[1:0]};

    // Select the encoding; fields a mnemonic does not use are forced to zero.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        word     = 32'h0000_0000;
        lo_word  = 32'h0000_0000;
        legal    = 1'b1;
        two_word = 1'b0;
        case (mnem)
            MN_ADDU: word = {OP_SPECIAL, rs, rt, rd, 5'b0, FN_ADDU};
            MN_SUBU: word = {OP_SPECIAL, rs, rt, rd, 5'b0, FN_SUBU};
            MN_SLTU: word = {OP_SPECIAL, rs, rt, rd, 5'b0, FN_SLTU};
            MN_JR:   word = {OP_SPECIAL, rs, 15'b0, FN_JR};
            MN_ORI:  word = {OP_ORI, rs, rt, imm[15:0]};
            MN_LW:   word = {OP_LW,  rs, rt, imm[15:0]};
            MN_SW:   word = {OP_SW,  rs, rt, imm[15:0]};
            MN_BEQ:  word = {OP_BEQ, rs, rt, imm[15:0]};
            MN_LUI:  word = {OP_LUI, 5'b0, rt, imm[15:0]};
            MN_JAL:  word = {OP_JAL, imm[27:2]};
            MN_NOP:  word = 32'h0000_0000;
`ifdef INSTR_ENC_LI_PSEUDO_EN
            MN_LI: begin
                word     = {OP_LUI, 5'b0, rt, imm[31:16]};
                lo_word  = {OP_ORI, rt, rt, imm[15:0]};
                two_word = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: one output register stage with valid/ready
// backpressure, sequential IM addressing with wrap, saturating word count
// and a sticky illegal-mnemonic flag.
// Optional feature macro: INSTR_ENC_LI_PSEUDO_EN (LI rt, imm32 -> LUI + ORI).
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          IM_WORDS  = 1024
) (
    input  logic         clk,
    input  logic         reset,
    instr_encoder_if.slave bus
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (IM_WORDS - 1));
    localparam logic [10:0] CNT_MAX   = 11'(IM_WORDS);

    state_t      state;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    logic [10:0] cnt_q;
    logic        err_q;

    logic [31:0] enc_word;
    logic [31:0] enc_lo;
    logic        enc_legal;
    logic        enc_two;
    logic        in_ready;
    logic        out_valid;
    logic        accept;
    logic        xfer;

    instr_enc_comb u_comb (
        .mnem     (bus.in_mnem),
        .rs       (bus.in_rs),
        .rt       (bus.in_rt),
        .rd       (bus.in_rd),
        .imm      (bus.in_imm),
        .word     (enc_word),
        .lo_word  (enc_lo),
        .legal    (enc_legal),
        .two_word (enc_two)
    );

    // Handshake decode: a full stage accepts only when it drains the same cycle.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state == ST_EMPTY) || ((state == ST_FULL) && bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign xfer      = out_valid && bus.out_ready;

`ifdef INSTR_ENC_LI_PSEUDO_EN
    logic [31:0] li_lo_q;
`else
    logic unused_li;
    assign unused_li = ^{enc_two, enc_lo};
`endif

    // State, output word, address, count and error registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; sequential state uses non-blocking assignments only.
        if (reset) begin
            state   <= ST_EMPTY;
            instr_q <= 32'h0000_0000;
            addr_q  <= BASE_ADDR;
            cnt_q   <= 11'd0;
            err_q   <= 1'b0;
`ifdef INSTR_ENC_LI_PSEUDO_EN
            li_lo_q <= 32'h0000_0000;
`endif
        end else begin
            if (accept && !enc_legal) begin
                err_q <= 1'b1;
            end
            if (xfer) begin
                addr_q <= (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 11'd1;
                end
            end
            case (state)
                ST_EMPTY, ST_FULL: begin
                    if (accept && enc_legal) begin
                        instr_q <= enc_word;
`ifdef INSTR_ENC_LI_PSEUDO_EN
                        li_lo_q <= enc_lo;
                        state   <= enc_two ? ST_LI_HI : ST_FULL;
`else
                        state   <= ST_FULL;
`endif
                    end else if (xfer) begin
                        state <= ST_EMPTY;
                    end
                end
`ifdef INSTR_ENC_LI_PSEUDO_EN
                ST_LI_HI: begin
                    if (xfer) begin
                        instr_q <= li_lo_q;
                        state   <= ST_FULL;
                    end
                end
`endif
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.word_cnt  = cnt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Inputs are driven and outputs sampled on the falling clock edge.
// Optional feature macro: INSTR_ENC_LI_PSEUDO_EN (selects LI tests).
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder #(
        .BASE_ADDR (32'h0000_3000),
        .IM_WORDS  (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    task automatic drive(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.in_mnem  = m;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_imm   = imm;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_mnem  = 4'd0;
        bus.in_rs    = 5'd0;
        bus.in_rt    = 5'd0;
        bus.in_rd    = 5'd0;
        bus.in_imm   = 32'd0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        apply_reset();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 00000000", bus.out_instr); end
        vectors++; if (bus.out_addr !== 32'h3000) begin miscompares++; $display("FAIL reset_addr: got %h want 00003000", bus.out_addr); end
        vectors++; if (bus.word_cnt !== 11'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", bus.word_cnt); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.err); end
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive(4'd0, 5'd1, 5'd2, 5'd3, 32'd0);            // ADDU
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL addu_valid: got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_instr !== 32'h00221821) begin miscompares++; $display("FAIL addu_instr: got %h want 00221821", bus.out_instr); end
        vectors++; if (bus.out_addr !== 32'h3000) begin miscompares++; $display("FAIL addu_addr: got %h want 00003000", bus.out_addr); end
        drive(4'd2, 5'd0, 5'd5, 5'd0, 32'h1234);          // ORI
        @(negedge clk);
        vectors++; if (bus.out_instr !== 32'h34051234) begin miscompares++; $display("FAIL ori_instr: got %h want 34051234", bus.out_instr); end
        vectors++; if (bus.out_addr !== 32'h3004) begin miscompares++; $display("FAIL ori_addr: got %h want 00003004", bus.out_addr); end
        vectors++; if (bus.word_cnt !== 11'd1) begin miscompares++; $display("FAIL ori_cnt: got %0d want 1", bus.word_cnt); end
        idle();
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.word_cnt !== 11'd2) begin miscompares++; $display("FAIL drain_cnt: got %0d want 2", bus.word_cnt); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive(4'd7, 5'd0, 5'd0, 5'd0, 32'h0000_300C);     // JAL
        @(negedge clk);
        vectors++; if (bus.out_instr !== 32'h0C000C03) begin miscompares++; $display("FAIL jal_instr: got %h want 0c000c03", bus.out_instr); end
        drive(4'd8, 5'd31, 5'd7, 5'd9, 32'hFFFF_FFFF);    // JR, unused fields junk
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
            vectors++; if (bus.out_instr !== 32'h0C000C03 || bus.out_addr !== 32'h3008 || bus.out_valid !== 1'b1)
                begin miscompares++; $display("FAIL stall_hold: got %h@%h v%b want 0c000c03@00003008 v1", bus.out_instr, bus.out_addr, bus.out_valid); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        vectors++; if (bus.out_instr !== 32'h03E00008 || bus.out_addr !== 32'h300C)
            begin miscompares++; $display("FAIL jr_word: got %h@%h want 03e00008@0000300c", bus.out_instr, bus.out_addr); end
        drive(4'd5, 5'd1, 5'd2, 5'd0, 32'h0000_FFFF);     // BEQ
        @(negedge clk);
        vectors++; if (bus.out_instr !== 32'h1022FFFF || bus.out_addr !== 32'h3010 || bus.out_valid !== 1'b1)
            begin miscompares++; $display("FAIL beq_word: got %h@%h v%b want 1022ffff@00003010 v1", bus.out_instr, bus.out_addr, bus.out_valid); end
        idle();
        @(negedge clk);
        vectors++; if (bus.word_cnt !== 11'd5 || bus.out_valid !== 1'b0)
            begin miscompares++; $display("FAIL b2b_drain: got cnt %0d v%b want cnt 5 v0", bus.word_cnt, bus.out_valid); end
    endtask

    task automatic test_illegal();
        drive(4'd13, 5'd1, 5'd1, 5'd1, 32'd1);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL illegal_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b want 1", bus.err); end
        vectors++; if (bus.out_addr !== 32'h3014) begin miscompares++; $display("FAIL illegal_addr: got %h want 00003014", bus.out_addr); end
        drive(4'd9, 5'd4, 5'd5, 5'd6, 32'd0);             // SLTU
        @(negedge clk);
        vectors++; if (bus.out_instr !== 32'h0085302B || bus.out_addr !== 32'h3014)
            begin miscompares++; $display("FAIL sltu_word: got %h@%h want 0085302b@00003014", bus.out_instr, bus.out_addr); end
        drive(4'd15, 5'd0, 5'd0, 5'd0, 32'd0);            // illegal while draining
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 32'h3018 || bus.err !== 1'b1)
            begin miscompares++; $display("FAIL illegal_full: got v%b %h err%b want v0 00003018 err1", bus.out_valid, bus.out_addr, bus.err); end
        idle();
    endtask

    task automatic test_encodings();
        vec_t tbl[6];
        tbl[0] = '{4'd1, 5'd7,  5'd8,  5'd9,  32'd0,         32'h00E84823}; // SUBU
        tbl[1] = '{4'd3, 5'd29, 5'd8,  5'd0,  32'h0000_0010, 32'h8FA80010}; // LW
        tbl[2] = '{4'd4, 5'd29, 5'd9,  5'd0,  32'h0000_FFFC, 32'hAFA9FFFC}; // SW
        tbl[3] = '{4'd6, 5'd3,  5'd4,  5'd7,  32'h1234_ABCD, 32'h3C04ABCD}; // LUI forces rs=0
        tbl[4] = '{4'd10, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'h00000000}; // NOP
        tbl[5] = '{4'd2, 5'd1,  5'd2,  5'd3,  32'hFFFF_8001, 32'h34228001}; // ORI uses imm[15:0]
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].mnem, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm);
            @(negedge clk);
            vectors++; if (bus.out_instr !== tbl[i].exp || bus.out_addr !== 32'h3000 + 32'(4 * i) || bus.out_valid !== 1'b1)
                begin miscompares++; $display("FAIL enc_%0d: got %h@%h v%b want %h@%h v1", i, bus.out_instr, bus.out_addr, bus.out_valid, tbl[i].exp, 32'h3000 + 32'(4 * i)); end
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.out_ready = 1'b1;
        drive(4'd10, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i <= 1024; i++) begin
            @(negedge clk);
            if (i == 1023) begin
                vectors++; if (bus.out_addr !== 32'h3FFC) begin miscompares++; $display("FAIL wrap_last_addr: got %h want 00003ffc", bus.out_addr); end
            end
            if (i == 1024) begin
                idle();
                vectors++; if (bus.out_addr !== 32'h3000) begin miscompares++; $display("FAIL wrap_addr: got %h want 00003000", bus.out_addr); end
                vectors++; if (bus.word_cnt !== 11'd1024) begin miscompares++; $display("FAIL wrap_cnt: got %0d want 1024", bus.word_cnt); end
            end
        end
        @(negedge clk);
        vectors++; if (bus.word_cnt !== 11'd1024 || bus.out_addr !== 32'h3004)
            begin miscompares++; $display("FAIL cnt_saturate: got %0d %h want 1024 00003004", bus.word_cnt, bus.out_addr); end
    endtask

`ifdef INSTR_ENC_LI_PSEUDO_EN
    task automatic test_li();
        apply_reset();
        bus.out_ready = 1'b1;
        drive(4'd11, 5'd0, 5'd8, 5'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(4'd0, 5'd1, 5'd2, 5'd3, 32'd0);             // ADDU queued behind LI
        #1;
        vectors++; if (bus.out_instr !== 32'h3C08DEAD || bus.out_addr !== 32'h3000)
            begin miscompares++; $display("FAIL li_hi: got %h@%h want 3c08dead@00003000", bus.out_instr, bus.out_addr); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL li_in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        vectors++; if (bus.out_instr !== 32'h3508BEEF || bus.out_addr !== 32'h3004)
            begin miscompares++; $display("FAIL li_lo: got %h@%h want 3508beef@00003004", bus.out_instr, bus.out_addr); end
        @(negedge clk);
        vectors++; if (bus.out_instr !== 32'h00221821 || bus.out_addr !== 32'h3008)
            begin miscompares++; $display("FAIL li_follow: got %h@%h want 00221821@00003008", bus.out_instr, bus.out_addr); end
        idle();
        @(negedge clk);
        vectors++; if (bus.word_cnt !== 11'd3) begin miscompares++; $display("FAIL li_cnt: got %0d want 3", bus.word_cnt); end
        // Reset while the LUI half is still held.
        bus.out_ready = 1'b0;
        drive(4'd11, 5'd0, 5'd8, 5'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 32'h3000)
            begin miscompares++; $display("FAIL li_reset: got v%b %h want v0 00003000", bus.out_valid, bus.out_addr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL li_reset_no_ori: got v%b want v0", bus.out_valid); end
        end
    endtask
`else
    task automatic test_li();
        apply_reset();
        bus.out_ready = 1'b1;
        drive(4'd11, 5'd0, 5'd8, 5'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        idle();
        vectors++; if (bus.out_valid !== 1'b0 || bus.err !== 1'b1)
            begin miscompares++; $display("FAIL li_disabled: got v%b err%b want v0 err1", bus.out_valid, bus.err); end
        @(negedge clk);
        vectors++; if (bus.word_cnt !== 11'd0 || bus.out_addr !== 32'h3000)
            begin miscompares++; $display("FAIL li_disabled_addr: got %0d %h want 0 00003000", bus.word_cnt, bus.out_addr); end
    endtask
`endif

    initial begin
        idle();
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_encodings();
        test_wrap();
        test_li();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the P4 instruction decoder: accepts symbolic instruction requests (mnemonic + fields) and emits 32-bit MIPS words.
- Each word is paired with a sequential IM byte address.
- Used by the testbench/boot path to stream programs into instruction memory.
- Single output register stage with valid/ready backpressure; supports the P4 ISA subset.

Parameters:
BASE_ADDR, 32'h0000_3000, address of first emitted word
IM_WORDS, 1024, IM depth in words; address wraps after this many words

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid&&in_ready
in_mnem  input  4  mnemonic code: 0 ADDU, 1 SUBU, 2 ORI, 3 LW, 4 SW, 5 BEQ, 6 LUI, 7 JAL, 8 JR, 9 SLTU, 10 NOP, 11 LI (pseudo); 12-15 illegal
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field
in_imm  input  32  immediate; I-type uses [15:0], JAL uses [27:2], LI uses all 32
out_valid  output  1  word/address valid
out_ready  input  1  consumer ready; transfer when out_valid&&out_ready
out_instr  output  32  encoded instruction
out_addr  output  32  IM byte address of out_instr
word_cnt  output  11  words transferred since reset, saturates at IM_WORDS
err  output  1  sticky: an illegal mnemonic was accepted

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, word_cnt=0, err=0, state=EMPTY.
  - Any pending word is discarded, including a half-emitted LI.
- Encodings:
  - R-type: {6'b0, rs, rt, rd, 5'b0, funct}; funct ADDU 100001, SUBU 100011, SLTU 101011.
  - JR: {6'b0, rs, 15'b0, 6'b001000}.
  - I-type: {op, rs, rt, imm[15:0]}; op ORI 001101, LW 100011, SW 101011, BEQ 000100, LUI 001111 (LUI forces rs=0).
  - JAL: {6'b000011, imm[27:2]}.
  - NOP: 32'h0000_0000.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=out_ready.
  - LI_HI: out_valid=1 holding the LUI half, in_ready=0.
- Latency: an accepted request's word appears on out_instr/out_valid the next cycle. Throughput is 1 word/cycle while out_ready=1.
- Transitions:
  - EMPTY -> FULL on legal accept.
  - FULL stays FULL on simultaneous out-transfer + legal accept (pass-through, no bubble).
  - FULL -> EMPTY on out-transfer with no accept.
  - Outputs hold stable while out_valid && !out_ready.
- Illegal mnemonic:
  - Request is accepted (handshake completes) but produces no word.
  - err sets and stays set until reset.
  - State follows the "no accept" path.
- Address:
  - out_addr advances by 4 on each out transfer.
  - After word IM_WORDS-1 (BASE_ADDR + 4*(IM_WORDS-1)) it wraps to BASE_ADDR.
  - word_cnt increments per transfer and saturates at IM_WORDS.
- rd/rt/rs fields not used by a mnemonic are ignored; the encoding forces those bits to 0.

Optional Feature:
- Macro INSTR_ENC_LI_PSEUDO_EN.
- With it, mnemonic 11 (LI rt, imm32) expands to two words:
  - Word 1: LUI rt, imm[31:16], emitted from state LI_HI.
  - Word 2: ORI rt, rt, imm[15:0], loaded after the LUI half transfers; state then moves to FULL.
  - in_ready=0 until the LUI half transfers, so input stalls one slot.
  - Each half consumes its own address and word_cnt slot.
- Without it:
  - Mnemonic 11 is illegal (sets err, no word).
  - State LI_HI does not exist.

Decomposition:
- Shared package (instr_enc_pkg):
  - Mnemonic codes.
  - Opcode/funct constants, matching the decoder's.
  - State encoding.
- Sub-module instr_enc_comb: pure combinational mnemonic+fields -> 32-bit word + legal flag.
- Top: handshake, state register, address/count logic.

Test Plan:
- After reset, send ADDU rs=1 rt=2 rd=3 with out_ready=1 -> next cycle out_instr=32'h00221821, out_addr=0x3000; ORI rs=0 rt=5 imm=0x1234 -> 32'h34051234 at 0x3004.
- Hold out_ready=0 with one word pending -> in_ready=0, out_instr/out_addr stable; release -> back-to-back words with no bubble.
- JAL imm=0x0000_300C -> 32'h0C000C03; JR rs=31 -> 32'h03E00008; BEQ rs=1 rt=2 imm=0xFFFF -> 32'h1022FFFF.
- Mnemonic 13 -> handshake completes, no out_valid, err=1, out_addr unchanged; next SLTU rs=4 rt=5 rd=6 -> 32'h0085302B.
- Stream IM_WORDS+1 NOPs -> last word's out_addr=0x3000 (wrap), word_cnt=1024 saturated.
- With INSTR_ENC_LI_PSEUDO_EN: LI rt=8 imm=0xDEADBEEF -> 32'h3C08DEAD then 32'h3508BEEF at consecutive addresses, in_ready low during the first half. Reset asserted mid-LI -> out_valid=0 and the ORI half is never emitted.
